// File: rtl/shift_ring_counter_pkg.sv
// -----------------------------------------------------------------------------
// shift_cnt_pkg
// Shared types and helpers for the shift-register counter family.
//   cnt_mode_e    : RING (one-hot rotate) / JOHNSON (twisted ring)
//   cnt_dir_e     : LEFT (toward MSB) / RIGHT (toward LSB)
//   johnson_valid : 1 when a vector has at most one adjacent-bit transition
// Vectors up to MAX_WIDTH bits are supported by johnson_valid.
// -----------------------------------------------------------------------------
package shift_cnt_pkg;

  typedef enum logic {
    RING    = 1'b0,
    JOHNSON = 1'b1
  } cnt_mode_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } cnt_dir_e;

  localparam int MAX_WIDTH = 64;

  // Legal Johnson codes are a run of ones at one end and zeros at the other,
  // i.e. at most one place where neighbouring bits differ. Only the low
  // 'width' bits of vec take part; the loop bound is fixed so it unrolls.
  function automatic logic johnson_valid(input logic [MAX_WIDTH-1:0] vec,
                                         input int width);
    int n_trans;
    n_trans = 0;
    for (int i = 0; i < MAX_WIDTH - 1; i++) begin
      if ((i < width - 1) && (vec[i] != vec[i+1])) n_trans++;
    end
    return (n_trans <= 1);
  endfunction

endpackage

// File: rtl/shift_ring_counter_if.sv
// -----------------------------------------------------------------------------
// shift_ring_counter_if
// Control/status bundle of shift_ring_counter. i_* are driven by the master
// (the controller), o_* by the slave (the counter).
//   i_en, i_mode, i_dir, i_load, i_load_val : step / configuration / load
//   o_count, o_phase, o_wrap, o_err         : counter state and status
// -----------------------------------------------------------------------------
interface shift_ring_counter_if
  import shift_cnt_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int PW    = $clog2(2 * WIDTH)
);

  logic             i_en;
  cnt_mode_e        i_mode;
  cnt_dir_e         i_dir;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic [WIDTH-1:0] o_count;
  logic [PW-1:0]    o_phase;
  logic             o_wrap;
  logic             o_err;

  modport master (
    output i_en, i_mode, i_dir, i_load, i_load_val,
    input  o_count, o_phase, o_wrap, o_err
  );

  modport slave (
    input  i_en, i_mode, i_dir, i_load, i_load_val,
    output o_count, o_phase, o_wrap, o_err
  );

endinterface

// File: rtl/shift_ring_counter_legal_chk.sv
// -----------------------------------------------------------------------------
// shift_ring_legal_chk
// Purely combinational legality check of a ring/Johnson counter code.
//   i_count : counter value (WIDTH bits)
//   i_mode  : RING -> legal iff exactly one bit set
//             JOHNSON -> legal iff at most one adjacent-bit transition
//   o_err   : 1 when i_count is illegal for i_mode
// -----------------------------------------------------------------------------
module shift_ring_legal_chk
  import shift_cnt_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_count,
  input  cnt_mode_e        i_mode,
  output logic             o_err
);

  logic [MAX_WIDTH-1:0] w_vec;
  logic                 w_ring_bad;
  logic                 w_john_bad;

  assign w_vec      = MAX_WIDTH'(i_count);
  assign w_ring_bad = ($countones(i_count) != 1);
  assign w_john_bad = !johnson_valid(w_vec, WIDTH);
  assign o_err      = (i_mode == RING) ? w_ring_bad : w_john_bad;

endmodule

// File: rtl/shift_ring_counter.sv
// -----------------------------------------------------------------------------
// shift_ring_counter
// Parametrised ring / Johnson shift counter with phase index, wrap pulse and
// illegal-code detection.
//   clk   : clock, rising edge
//   rst   : asynchronous, active-high reset
//   bus   : shift_ring_counter_if.slave
//           i_en     advance one step      i_mode  RING / JOHNSON
//           i_dir    LEFT / RIGHT          i_load  synchronous parallel load
//           i_load_val                     o_count counter state
//           o_phase  step index mod period o_wrap  returned to reset pattern
//           o_err    illegal code for the current mode
// Priority each cycle: mode change > load > en > hold.
// Build option: define SHIFT_RING_COUNTER_SELFCORRECT_EN to make an en step
// taken on an illegal code reload the reset pattern instead of shifting.
// -----------------------------------------------------------------------------
module shift_ring_counter
  import shift_cnt_pkg::*;
#(
  parameter int               WIDTH     = 6,
  parameter logic [WIDTH-1:0] RING_INIT = WIDTH'(1),
  parameter int               PW        = $clog2(2 * WIDTH)
) (
  input logic                 clk,
  input logic                 rst,
  shift_ring_counter_if.slave bus
);

  localparam logic [PW-1:0] RING_LAST = PW'(WIDTH - 1);
  localparam logic [PW-1:0] JOHN_LAST = PW'(2 * WIDTH - 1);

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_phase;
  logic             r_wrap;
  cnt_mode_e        r_mode_q;

  logic [WIDTH-1:0] w_pat_new;
  logic [WIDTH-1:0] w_pat_cur;
  logic [WIDTH-1:0] w_step;
  logic [PW-1:0]    w_last;
  logic [PW-1:0]    w_phase_step;
  logic             w_fb_left;
  logic             w_fb_right;
  logic             w_err;
  logic             w_correct;

  function automatic logic [WIDTH-1:0] reset_pattern(input cnt_mode_e m);
    return (m == RING) ? RING_INIT : '0;
  endfunction

  // Pattern for a pending mode change, and for the mode currently running.
  assign w_pat_new = reset_pattern(bus.i_mode);
  assign w_pat_cur = reset_pattern(r_mode_q);

  // The bit wrapping around the end is inverted in Johnson mode only.
  assign w_fb_left  = r_count[WIDTH-1] ^ (r_mode_q == JOHNSON);
  assign w_fb_right = r_count[0]       ^ (r_mode_q == JOHNSON);
  assign w_step     = (bus.i_dir == RIGHT) ? {w_fb_right, r_count[WIDTH-1:1]}
                                           : {r_count[WIDTH-2:0], w_fb_left};

  assign w_last = (r_mode_q == RING) ? RING_LAST : JOHN_LAST;

  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned,
    // which would infer a latch.
    w_phase_step = r_phase;
    if (bus.i_dir == LEFT) begin
      w_phase_step = (r_phase == w_last) ? '0 : r_phase + 1'b1;
    end else begin
      w_phase_step = (r_phase == '0) ? w_last : r_phase - 1'b1;
    end
  end

  shift_ring_legal_chk #(
    .WIDTH (WIDTH)
  ) u_legal_chk (
    .i_count (r_count),
    .i_mode  (r_mode_q),
    .o_err   (w_err)
  );

`ifdef SHIFT_RING_COUNTER_SELFCORRECT_EN
  assign w_correct = w_err;
`else
  assign w_correct = 1'b0;
`endif

  // NOTE: non-blocking assignments for all registered state so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= RING_INIT;
      r_phase  <= '0;
      r_wrap   <= 1'b0;
      r_mode_q <= RING;
    end else if (bus.i_mode != r_mode_q) begin
      r_count  <= w_pat_new;
      r_phase  <= '0;
      r_wrap   <= 1'b0;
      r_mode_q <= bus.i_mode;
    end else if (bus.i_load) begin
      r_count <= bus.i_load_val;
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else if (bus.i_en) begin
      if (w_correct) begin
        // Recovery step: jump straight to the reset pattern, no wrap pulse.
        r_count <= w_pat_cur;
        r_phase <= '0;
        r_wrap  <= 1'b0;
      end else begin
        r_count <= w_step;
        r_phase <= w_phase_step;
        r_wrap  <= (w_step == w_pat_cur);
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign bus.o_count = r_count;
  assign bus.o_phase = r_phase;
  assign bus.o_wrap  = r_wrap;
  assign bus.o_err   = w_err;

endmodule

// File: tb/tb_shift_ring_counter.sv
// -----------------------------------------------------------------------------
// tb_shift_ring_counter
// Directed walk through the counter's main scenarios followed by randomized
// traffic, all compared against a behavioural model of the counter that works
// on integer codes and a phase number.
// -----------------------------------------------------------------------------
module tb_shift_ring_counter;
  import shift_cnt_pkg::*;

  localparam int             W    = 6;
  localparam logic [W-1:0]   INIT = 6'b000001;
  localparam int             MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_count;
  int m_phase;
  int m_mode;
  int m_wrap;

  shift_ring_counter_if #(.WIDTH(W)) bus ();

  shift_ring_counter #(
    .WIDTH     (W),
    .RING_INIT (INIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pat(input int mode);
    return (mode != 0) ? 0 : int'(INIT);
  endfunction

  function automatic int period(input int mode);
    return (mode != 0) ? 2 * W : W;
  endfunction

  function automatic int model_err(input int c, input int mode);
    int t;
    t = 0;
    if (mode == 0) return ($countones(c) != 1) ? 1 : 0;
    for (int i = 0; i < W - 1; i++) begin
      if (((c >> i) & 1) != ((c >> (i + 1)) & 1)) t++;
    end
    return (t > 1) ? 1 : 0;
  endfunction

  // Ring rotates the code; Johnson shifts in the complement of the bit leaving.
  function automatic int next_code(input int c, input int mode, input int dir);
    int leaving;
    if (dir == 0) begin
      leaving = (c >> (W - 1)) & 1;
      return ((c << 1) & MASK) | ((mode != 0) ? (1 - leaving) : leaving);
    end
    leaving = c & 1;
    return (c >> 1) | (((mode != 0) ? (1 - leaving) : leaving) << (W - 1));
  endfunction

  task automatic model_reset();
    m_count = int'(INIT);
    m_phase = 0;
    m_mode  = 0;
    m_wrap  = 0;
  endtask

  task automatic model_cycle(input int en, input int load, input int lv,
                             input int mode, input int dir);
    int n;
    n = period(m_mode);
    if (mode != m_mode) begin
      m_mode  = mode;
      m_count = pat(mode);
      m_phase = 0;
      m_wrap  = 0;
    end else if (load != 0) begin
      m_count = lv;
      m_phase = 0;
      m_wrap  = 0;
    end else if (en != 0) begin
`ifdef SHIFT_RING_COUNTER_SELFCORRECT_EN
      if (model_err(m_count, m_mode) != 0) begin
        m_count = pat(m_mode);
        m_phase = 0;
        m_wrap  = 0;
      end else
`endif
      begin
        m_count = next_code(m_count, m_mode, dir);
        m_phase = (dir != 0) ? (m_phase + n - 1) % n : (m_phase + 1) % n;
        m_wrap  = (m_count == pat(m_mode)) ? 1 : 0;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(bus.o_count), 32'(m_count));
    check({tag, ".phase"}, 32'(bus.o_phase), 32'(m_phase));
    check({tag, ".wrap"},  32'(bus.o_wrap),  32'(m_wrap));
    check({tag, ".err"},   32'(bus.o_err),   32'(model_err(m_count, m_mode)));
  endtask

  // Apply one cycle of inputs, advance the model, sample just after the edge.
  task automatic drive(input string tag, input int en, input int load, input int lv,
                       input int mode, input int dir);
    bus.i_en       = (en != 0);
    bus.i_load     = (load != 0);
    bus.i_load_val = W'(lv);
    bus.i_mode     = (mode != 0) ? JOHNSON : RING;
    bus.i_dir      = (dir != 0) ? RIGHT : LEFT;
    model_cycle(en, load, lv, mode, dir);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    int cur_mode;
    rst            = 1'b1;
    bus.i_en       = 1'b0;
    bus.i_load     = 1'b0;
    bus.i_load_val = '0;
    bus.i_mode     = RING;
    bus.i_dir      = LEFT;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: ring, left, continuous enable
    for (int i = 0; i < 13; i++) drive("ring_left", 1, 0, 0, 0, 0);
    check("tp1_count", 32'(bus.o_count), 32'h02);
    check("tp1_phase", 32'(bus.o_phase), 32'd1);

    // 2: switch to Johnson (en ignored on the change cycle), full period left
    drive("mode_to_john", 1, 0, 0, 1, 0);
    check("tp2_clear", 32'(bus.o_count), 32'h00);
    for (int i = 0; i < 12; i++) drive("john_left", 1, 0, 0, 1, 0);
    check("tp2_wrap", 32'(bus.o_wrap), 32'd1);

    // 3: reach 000011 (phase 2) then reverse
    drive("john_left2", 1, 0, 0, 1, 0);
    drive("john_left2", 1, 0, 0, 1, 0);
    check("tp3_start", 32'(bus.o_count), 32'h03);
    for (int i = 0; i < 3; i++) drive("john_right", 1, 0, 0, 1, 1);
    check("tp3_count", 32'(bus.o_count), 32'h20);
    check("tp3_phase", 32'(bus.o_phase), 32'd11);

    // 4: back to ring, load an illegal code, then one step
    drive("mode_to_ring", 0, 0, 0, 0, 0);
    drive("load_bad", 0, 1, 6'b000101, 0, 0);
    check("tp4_err", 32'(bus.o_err), 32'd1);
    drive("bad_step", 1, 0, 0, 0, 0);
`ifdef SHIFT_RING_COUNTER_SELFCORRECT_EN
    check("tp4_fix", 32'(bus.o_count), 32'h01);
`else
    check("tp4_shift", 32'(bus.o_count), 32'h0A);
`endif

    // 5: load beats en; then asynchronous reset between clock edges
    drive("load_en", 1, 1, 6'b010000, 0, 0);
    check("tp5_load", 32'(bus.o_count), 32'h10);
    for (int i = 0; i < 3; i++) drive("after_load", 1, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    cur_mode = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) cur_mode = 1 - cur_mode;
      drive("random",
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            ($urandom_range(0, 11) == 0) ? 1 : 0,
            int'($urandom_range(0, MASK)),
            cur_mode,
            int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
